// File: rtl/jtcontra_pkg.sv
// Shared types for the ROM slot responder: slot ids, FSM states, SDRAM address width.
// Latency: none (types only); backpressure: n/a.
package jtcontra_pkg;

    localparam int SDRAM_AW = 22;

    typedef enum logic [1:0] {
        SLOT_MAIN = 2'd0,
        SLOT_SND  = 2'd1,
        SLOT_PCM  = 2'd2
    } slot_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/jtcontra_rom_cache1.sv
// One-word cache for a byte-wide ROM slot; hit/ok/data are combinational from registered state.
// Latency: hit 0 cycles, fill visible the cycle after fill_en; backpressure: none, miss stays up until filled.
module jtcontra_rom_cache1
    import jtcontra_pkg::*;
#(
    parameter int AW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    output logic [7:0]    data,
    output logic          ok,
    output logic          miss,
    input  logic          fill_en,
    input  logic [AW-2:0] fill_tag,
    input  logic [15:0]   fill_word
);

    logic          valid_q, valid_d;
    logic [AW-2:0] tag_q,   tag_d;
    logic [15:0]   word_q,  word_d;
    logic          hit;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        word_d  = word_q;
        if (fill_en) begin
            valid_d = 1'b1;
            tag_d   = fill_tag;
            word_d  = fill_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            word_q  <= word_d;
        end
    end

    assign hit  = cs & valid_q & (addr[AW-1:1] == tag_q);
    assign ok   = hit;
    assign miss = cs & ~hit;
    assign data = addr[0] ? word_q[15:8] : word_q[7:0];

endmodule

// File: rtl/jtcontra_rom_slots.sv
// Serves main/snd/pcm byte ROM slots from one 16-bit SDRAM read port, fixed priority main > snd > pcm.
// Latency: miss->req 1 cycle, ok the cycle after data_rdy; backpressure: sdram_req held until sdram_ack, one read in flight.
module jtcontra_rom_slots
    import jtcontra_pkg::*;
#(
    parameter int                  MAIN_AW     = 17,
    parameter int                  SND_AW      = 15,
    parameter int                  PCM_AW      = 17,
    parameter logic [SDRAM_AW-1:0] MAIN_OFFSET = 22'h00_0000,
    parameter logic [SDRAM_AW-1:0] SND_OFFSET  = 22'h01_0000,
    parameter logic [SDRAM_AW-1:0] PCM_OFFSET  = 22'h01_4000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                main_cs,
    input  logic [MAIN_AW-1:0]  main_addr,
    output logic [7:0]          main_data,
    output logic                main_ok,
    input  logic                snd_cs,
    input  logic [SND_AW-1:0]   snd_addr,
    output logic [7:0]          snd_data,
    output logic                snd_ok,
    input  logic                pcm_cs,
    input  logic [PCM_AW-1:0]   pcm_addr,
    output logic [7:0]          pcm_data,
    output logic                pcm_ok,
    output logic                sdram_req,
    output logic [SDRAM_AW-1:0] sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [15:0]         data_read
);

    localparam int MAX_AW = (MAIN_AW > SND_AW) ? ((MAIN_AW > PCM_AW) ? MAIN_AW : PCM_AW)
                                               : ((SND_AW  > PCM_AW) ? SND_AW  : PCM_AW);
    localparam int TW = MAX_AW - 1;

    state_e              state_q,   state_d;
    slot_e               slot_q,    slot_d;
    logic [TW-1:0]       lat_tag_q, lat_tag_d;
    logic                req_q,     req_d;
    logic [SDRAM_AW-1:0] addr_q,    addr_d;

    logic main_miss, snd_miss, pcm_miss;
    logic fill;

    // A same-cycle ack+data_rdy in REQ counts as a completed read.
    assign fill = data_rdy & ((state_q == ST_WAIT) | ((state_q == ST_REQ) & sdram_ack));

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        lat_tag_d = lat_tag_q;
        req_d     = req_q;
        addr_d    = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (main_miss) begin
                    slot_d    = SLOT_MAIN;
                    lat_tag_d = TW'(main_addr[MAIN_AW-1:1]);
                    addr_d    = MAIN_OFFSET + SDRAM_AW'(main_addr[MAIN_AW-1:1]);
                    req_d     = 1'b1;
                    state_d   = ST_REQ;
                end else if (snd_miss) begin
                    slot_d    = SLOT_SND;
                    lat_tag_d = TW'(snd_addr[SND_AW-1:1]);
                    addr_d    = SND_OFFSET + SDRAM_AW'(snd_addr[SND_AW-1:1]);
                    req_d     = 1'b1;
                    state_d   = ST_REQ;
                end else if (pcm_miss) begin
                    slot_d    = SLOT_PCM;
                    lat_tag_d = TW'(pcm_addr[PCM_AW-1:1]);
                    addr_d    = PCM_OFFSET + SDRAM_AW'(pcm_addr[PCM_AW-1:1]);
                    req_d     = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    state_d = data_rdy ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (data_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            slot_q    <= SLOT_MAIN;
            lat_tag_q <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            lat_tag_q <= lat_tag_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
        end
    end

    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

    jtcontra_rom_cache1 #(.AW(MAIN_AW)) u_main (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (main_cs),
        .addr      (main_addr),
        .data      (main_data),
        .ok        (main_ok),
        .miss      (main_miss),
        .fill_en   (fill & (slot_q == SLOT_MAIN)),
        .fill_tag  (lat_tag_q[MAIN_AW-2:0]),
        .fill_word (data_read)
    );

    jtcontra_rom_cache1 #(.AW(SND_AW)) u_snd (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (snd_cs),
        .addr      (snd_addr),
        .data      (snd_data),
        .ok        (snd_ok),
        .miss      (snd_miss),
        .fill_en   (fill & (slot_q == SLOT_SND)),
        .fill_tag  (lat_tag_q[SND_AW-2:0]),
        .fill_word (data_read)
    );

    jtcontra_rom_cache1 #(.AW(PCM_AW)) u_pcm (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (pcm_cs),
        .addr      (pcm_addr),
        .data      (pcm_data),
        .ok        (pcm_ok),
        .miss      (pcm_miss),
        .fill_en   (fill & (slot_q == SLOT_PCM)),
        .fill_tag  (lat_tag_q[PCM_AW-2:0]),
        .fill_word (data_read)
    );

endmodule

// File: tb/tb_jtcontra_rom_slots.sv
// Scoreboard bench for jtcontra_rom_slots: expected SDRAM requests and ok/data events are queued by the stimulus.
// The PCM offset is set to 22'h3F_FFFF so every PCM request exercises the 22-bit wrap.
module tb_jtcontra_rom_slots;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        main_cs, snd_cs, pcm_cs;
    logic [16:0] main_addr;
    logic [14:0] snd_addr;
    logic [16:0] pcm_addr;
    logic [7:0]  main_data, snd_data, pcm_data;
    logic        main_ok, snd_ok, pcm_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack, data_rdy;
    logic [15:0] data_read;

    always #5 clk = ~clk;

    jtcontra_rom_slots #(
        .MAIN_AW     (17),
        .SND_AW      (15),
        .PCM_AW      (17),
        .MAIN_OFFSET (22'h00_0000),
        .SND_OFFSET  (22'h01_0000),
        .PCM_OFFSET  (22'h3F_FFFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .main_cs    (main_cs),
        .main_addr  (main_addr),
        .main_data  (main_data),
        .main_ok    (main_ok),
        .snd_cs     (snd_cs),
        .snd_addr   (snd_addr),
        .snd_data   (snd_data),
        .snd_ok     (snd_ok),
        .pcm_cs     (pcm_cs),
        .pcm_addr   (pcm_addr),
        .pcm_data   (pcm_data),
        .pcm_ok     (pcm_ok),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .data_rdy   (data_rdy),
        .data_read  (data_read)
    );

    typedef struct {
        int         slot;
        logic [7:0] dat;
    } exp_t;

    exp_t        exp_ok[$];
    logic [21:0] exp_req[$];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: one event per rising ok, or per address change while ok holds.
    logic [2:0]  ok_prev = '0;
    logic [16:0] adr_prev[3];
    logic        req_prev = 1'b0;

    always @(negedge clk) begin
        logic [2:0]  ok_v;
        logic [7:0]  dat_v[3];
        logic [16:0] adr_v[3];
        exp_t        e;
        logic [21:0] ea;
        ok_v     = {pcm_ok, snd_ok, main_ok};
        dat_v[0] = main_data;  dat_v[1] = snd_data;             dat_v[2] = pcm_data;
        adr_v[0] = main_addr;  adr_v[1] = {2'b00, snd_addr};    adr_v[2] = pcm_addr;
        if (rst_n === 1'b1) begin
            for (int s = 0; s < 3; s++) begin
                if (ok_v[s] && (!ok_prev[s] || adr_v[s] != adr_prev[s])) begin
                    vectors++;
                    if (exp_ok.size() == 0) begin
                        miscompares++;
                        $display("FAIL ok_event: slot %0d data %h with nothing expected", s, dat_v[s]);
                    end else begin
                        e = exp_ok.pop_front();
                        if (e.slot != s || dat_v[s] !== e.dat) begin
                            miscompares++;
                            $display("FAIL ok_event: got slot %0d data %h expected slot %0d data %h",
                                     s, dat_v[s], e.slot, e.dat);
                        end
                    end
                end
            end
            if (sdram_req && !req_prev) begin
                vectors++;
                if (exp_req.size() == 0) begin
                    miscompares++;
                    $display("FAIL sdram_req: request at %h with nothing expected", sdram_addr);
                end else begin
                    ea = exp_req.pop_front();
                    if (sdram_addr !== ea) begin
                        miscompares++;
                        $display("FAIL sdram_addr: got %h expected %h", sdram_addr, ea);
                    end
                end
            end
        end
        ok_prev  = ok_v;
        req_prev = sdram_req;
        for (int s = 0; s < 3; s++) adr_prev[s] = adr_v[s];
    end

    task automatic wait_req();
        int n = 0;
        @(negedge clk);
        while (sdram_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sdram_req !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_req: timeout, sdram_req %b expected 1", sdram_req);
        end
    endtask

    task automatic do_ack(input int dly);
        repeat (dly) @(posedge clk);
        #1 sdram_ack = 1'b1;
        @(posedge clk);
        #1 sdram_ack = 1'b0;
    endtask

    task automatic do_rdy(input int dly, input logic [15:0] d);
        repeat (dly) @(posedge clk);
        #1 data_rdy = 1'b1;
        data_read = d;
        @(posedge clk);
        #1 data_rdy = 1'b0;
    endtask

    task automatic push_ok(input int slot, input logic [7:0] d);
        exp_t e;
        e.slot = slot;
        e.dat  = d;
        exp_ok.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 300000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        main_cs = 0; snd_cs = 0; pcm_cs = 0;
        main_addr = '0; snd_addr = '0; pcm_addr = '0;
        sdram_ack = 0; data_rdy = 0; data_read = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sdram_req",  32'(sdram_req), 32'd0);
        check("rst_sdram_addr", 32'(sdram_addr), 32'd0);
        check("rst_ok",         32'({pcm_ok, snd_ok, main_ok}), 32'd0);
        check("rst_data",       32'({pcm_data, snd_data, main_data}), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Basic miss, then same-word hit on the odd byte.
        main_cs = 1; main_addr = 17'h00004;
        exp_req.push_back(22'h000002);
        push_ok(0, 8'h5A);
        wait_req();
        do_ack(3);
        do_rdy(5, 16'hA55A);
        idle(2);
        push_ok(0, 8'hA5);
        main_addr = 17'h00005;
        idle(4);
        check("hit_no_req", 32'(sdram_req), 32'd0);
        main_cs = 0;
        idle(2);

        // Three simultaneous misses served in priority order.
        main_cs = 1; main_addr = 17'h00020;
        snd_cs  = 1; snd_addr  = 15'h0010;
        pcm_cs  = 1; pcm_addr  = 17'h00002;
        exp_req.push_back(22'h000010);
        exp_req.push_back(22'h010008);
        exp_req.push_back(22'h000000);
        push_ok(0, 8'h34);
        push_ok(1, 8'h78);
        push_ok(2, 8'hBC);
        wait_req(); do_ack(1); do_rdy(2, 16'h1234);
        wait_req(); do_ack(1); do_rdy(2, 16'h5678);
        wait_req(); do_ack(1); do_rdy(2, 16'h9ABC);
        idle(2);
        check("all_ok", 32'({pcm_ok, snd_ok, main_ok}), 32'h7);
        main_cs = 0; snd_cs = 0; pcm_cs = 0;
        idle(2);

        // Address changes while the fill is in flight.
        main_cs = 1; main_addr = 17'h00004;
        exp_req.push_back(22'h000002);
        wait_req();
        do_ack(1);
        @(posedge clk);
        #1 main_addr = 17'h00100;
        exp_req.push_back(22'h000080);
        push_ok(0, 8'hEF);
        do_rdy(2, 16'hC0DE);
        @(negedge clk);
        check("stale_fill_ok", 32'(main_ok), 32'd0);
        wait_req();
        do_ack(0);
        do_rdy(1, 16'hBEEF);
        idle(2);

        // ack and data_rdy in the same cycle.
        snd_cs = 1; snd_addr = 15'h0020;
        exp_req.push_back(22'h010010);
        push_ok(1, 8'h0E);
        wait_req();
        repeat (2) @(posedge clk);
        #1 sdram_ack = 1; data_rdy = 1; data_read = 16'h0F0E;
        @(posedge clk);
        #1 sdram_ack = 0; data_rdy = 0;
        @(negedge clk);
        check("ackrdy_req", 32'(sdram_req), 32'd0);
        check("ackrdy_ok",  32'(snd_ok), 32'd1);
        idle(1);
        snd_cs = 0;
        idle(2);

        // Reset during WAIT while main is hitting.
        pcm_cs = 1; pcm_addr = 17'h00010;
        exp_req.push_back(22'h000007);
        wait_req();
        do_ack(1);
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        check("arst_req",  32'(sdram_req), 32'd0);
        check("arst_addr", 32'(sdram_addr), 32'd0);
        check("arst_ok",   32'({pcm_ok, snd_ok, main_ok}), 32'd0);
        main_cs = 0; pcm_cs = 0;
        idle(2);
        rst_n = 1;
        do_rdy(1, 16'hFFFF);
        idle(1);
        pcm_cs = 1; pcm_addr = 17'h00010;
        exp_req.push_back(22'h000007);
        push_ok(2, 8'h11);
        #1;
        check("late_rdy_ok", 32'(pcm_ok), 32'd0);
        wait_req();
        do_ack(0);
        do_rdy(1, 16'h2211);
        idle(3);
        pcm_cs = 0;
        idle(3);

        check("queues_empty", 32'(exp_ok.size() + exp_req.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
